// File: rtl/psum_readback.sv
// psum_readback: read-side engine for the partial-sums bank.
// On a start pulse it reads row_count consecutive rows (wrapping mod 2048)
// through the bank's s_en/s_addr/s_dout port. Each returned 512-bit row goes
// into a small output FIFO, and the FIFO drives a valid/ready stream with
// m_tlast on the final row.
// Optional build macro PSUM_COL_MASK_EN: when defined, lanes above the
// latched last_col are zeroed as rows enter the FIFO.
module psum_readback #(
    parameter int RD_LATENCY = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    input  logic [10:0]  row_start,
    input  logic [11:0]  row_count,
    input  logic [4:0]   last_col,
    output logic         s_en,
    output logic [16:0]  s_addr,
    input  logic [511:0] s_dout,
    output logic [511:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic         m_tlast,
    output logic         busy,
    output logic         done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ISSUE  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_FINISH = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [10:0]           row_q, row_d;       // next row to issue
    logic [11:0]           left_q, left_d;     // issues still to make
    logic [11:0]           total_q, total_d;   // latched row_count
    logic [11:0]           beat_q, beat_d;     // beats accepted so far
    logic [RD_LATENCY-1:0] rd_pend_q, rd_pend_d;
    logic [CW-1:0]         fifo_count_q, fifo_count_d;
    logic [AW-1:0]         wptr_q, rptr_q;
    logic [511:0]          fifo_mem_q [FIFO_DEPTH];
    logic [511:0]          wdata;
    logic [10:0]           addr_row;
    logic [7:0]            inflight;
    logic                  push, pop, issue_ok, start_acc;

    function automatic logic [7:0] count_ones(input logic [RD_LATENCY-1:0] v);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            n = n + {7'd0, v[i]};
        end
        return n;
    endfunction

    assign start_acc = (state_q == ST_IDLE) && start;
    assign m_tvalid  = (fifo_count_q != '0);
    assign pop       = m_tvalid && m_tready;
    // The oldest pending read lands on s_dout this cycle.
    assign push      = rd_pend_q[RD_LATENCY-1];
    assign inflight  = count_ones(rd_pend_q);
    // A beat leaving this cycle frees its slot in time for a new read, which
    // keeps one row per cycle flowing when FIFO_DEPTH = RD_LATENCY+1.
    assign issue_ok  = (8'(fifo_count_q) + inflight) < (8'(FIFO_DEPTH) + 8'(pop));

    assign busy      = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done      = (state_q == ST_FINISH);
    assign m_tdata   = m_tvalid ? fifo_mem_q[rptr_q] : '0;
    assign m_tlast   = m_tvalid && (beat_q == total_q - 12'd1);
    assign s_addr    = s_en ? {addr_row, 6'b0} : 17'd0;

    // Read issue: the first row goes out in the start cycle straight from row_start.
    always_comb begin
        s_en     = 1'b0;
        addr_row = row_q;
        if (state_q == ST_IDLE) begin
            s_en     = start && (row_count != 12'd0);
            addr_row = row_start;
        end else if (state_q == ST_ISSUE) begin
            s_en = issue_ok;
        end
    end

    // Track each issued read until its data returns RD_LATENCY cycles later.
    always_comb begin
        rd_pend_d    = rd_pend_q << 1;
        rd_pend_d[0] = s_en;
    end

`ifdef PSUM_COL_MASK_EN
    logic [4:0] last_col_q;

    // Latch the highest live lane together with the other launch values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_col_q <= 5'd0;
        end else if (start_acc) begin
            last_col_q <= last_col;
        end
    end

    // Zero the lanes above last_col as the row enters the FIFO.
    always_comb begin
        wdata = s_dout;
        for (int i = 0; i < 32; i++) begin
            if (5'(i) > last_col_q) begin
                wdata[16*i +: 16] = 16'h0000;
            end
        end
    end
`else
    logic unused_last_col;
    assign unused_last_col = ^last_col;
    assign wdata = s_dout;
`endif

    // Sequencer next state: launch, issue, drain, then the done pulse.
    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        left_d       = left_q;
        total_d      = total_q;
        beat_d       = pop ? beat_q + 12'd1 : beat_q;
        fifo_count_d = fifo_count_q + CW'(push) - CW'(pop);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    total_d = row_count;
                    beat_d  = 12'd0;
                    if (row_count == 12'd0) begin
                        left_d  = 12'd0;
                        state_d = ST_FINISH;
                    end else begin
                        row_d   = row_start + 11'd1;
                        left_d  = row_count - 12'd1;
                        state_d = (row_count == 12'd1) ? ST_DRAIN : ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (s_en) begin
                    row_d  = row_q + 11'd1;
                    left_d = left_q - 12'd1;
                    if (left_q == 12'd1) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if ((inflight == 8'd0) &&
                    ((fifo_count_q == '0) || ((fifo_count_q == CW'(1)) && pop))) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset also drops any reads still in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            row_q        <= 11'd0;
            left_q       <= 12'd0;
            total_q      <= 12'd0;
            beat_q       <= 12'd0;
            rd_pend_q    <= '0;
            fifo_count_q <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            left_q       <= left_d;
            total_q      <= total_d;
            beat_q       <= beat_d;
            rd_pend_q    <= rd_pend_d;
            fifo_count_q <= fifo_count_d;
            wptr_q       <= wptr_q + AW'(push);
            rptr_q       <= rptr_q + AW'(pop);
        end
    end

    // FIFO storage; contents are only meaningful below fifo_count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= wdata;
        end
    end

endmodule

// File: tb/tb_psum_readback.sv
// Bench for psum_readback: a memory model answers the read port after LAT
// cycles, directed launches push expected rows into a queue, and a monitor
// pops and compares every accepted beat.
module tb_psum_readback;
    localparam int LAT   = 3;
    localparam int DEPTH = 4;
`ifdef PSUM_COL_MASK_EN
    localparam bit MASK_ON = 1'b1;
`else
    localparam bit MASK_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         start = 1'b0;
    logic [10:0]  row_start = 11'd0;
    logic [11:0]  row_count = 12'd0;
    logic [4:0]   last_col = 5'd31;
    logic         s_en;
    logic [16:0]  s_addr;
    logic [511:0] s_dout;
    logic [511:0] m_tdata;
    logic         m_tvalid;
    logic         m_tready = 1'b0;
    logic         m_tlast;
    logic         busy;
    logic         done;

    psum_readback #(.RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .start(start), .row_start(row_start),
        .row_count(row_count), .last_col(last_col), .s_en(s_en), .s_addr(s_addr),
        .s_dout(s_dout), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .m_tlast(m_tlast), .busy(busy), .done(done)
    );

    initial forever #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int issued = 0;
    int accepted = 0;
    int max_out = 0;
    int first_vld_cyc = 0;
    int last_acc_cyc = 0;
    bit seen_vld = 1'b0;
    logic [512:0] exp_q[$];
    logic [16:0]  addr_log[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] row_data(input logic [10:0] r);
        logic [511:0] d;
        logic [4:0]   l5;
        d = '0;
        for (int i = 0; i < 32; i++) begin
            l5 = 5'(i);
            d[16*i +: 16] = {r, l5};
        end
        return d;
    endfunction

    function automatic logic [511:0] exp_row(input logic [10:0] r, input logic [4:0] lc);
        logic [511:0] d;
        d = row_data(r);
        for (int i = 0; i < 32; i++) begin
            if (MASK_ON && (i > int'(lc))) d[16*i +: 16] = 16'h0000;
        end
        return d;
    endfunction

    function automatic logic rdy(input int pct);
        if (pct >= 100) return 1'b1;
        return int'($urandom_range(0, 99)) < pct;
    endfunction

    // Memory model: data for a read appears LAT cycles after s_en/s_addr.
    logic [10:0] pa [LAT];
    always @(posedge clk) begin
        pa[0] <= s_addr[16:6];
        for (int i = 1; i < LAT; i++) pa[i] <= pa[i-1];
    end
    assign s_dout = row_data(pa[LAT-1]);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic chk_addrs(input string nm, input logic [16:0] want[$]);
        chk({nm, " count"}, 512'(addr_log.size()), 512'(want.size()));
        for (int i = 0; i < want.size() && i < addr_log.size(); i++)
            chk(nm, 512'(addr_log[i]), 512'(want[i]));
    endtask

    // Monitor: scoreboard pops, hold-stability, issue log, occupancy.
    initial begin
        logic [512:0] e;
        logic [511:0] hold_d;
        logic         hold_l;
        bit           stall;
        stall = 1'b0;
        hold_d = '0;
        hold_l = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                stall = 1'b0;
                issued = 0;
                accepted = 0;
            end else begin
                if (stall) begin
                    compared++;
                    if (m_tvalid !== 1'b1 || m_tdata !== hold_d || m_tlast !== hold_l) begin
                        mismatched++;
                        $display("FAIL hold cyc %0d: valid=%b last=%b data=%h required valid=1 last=%b data=%h",
                                 cyc, m_tvalid, m_tlast, m_tdata, hold_l, hold_d);
                    end
                end
                if (m_tvalid && !seen_vld) begin
                    seen_vld = 1'b1;
                    first_vld_cyc = cyc;
                end
                if (m_tvalid && m_tready) begin
                    compared++;
                    if (exp_q.size() == 0) begin
                        mismatched++;
                        $display("FAIL beat cyc %0d: unexpected beat last=%b data=%h, required none",
                                 cyc, m_tlast, m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        if ({m_tlast, m_tdata} !== e) begin
                            mismatched++;
                            $display("FAIL beat cyc %0d: last=%b data=%h required last=%b data=%h",
                                     cyc, m_tlast, m_tdata, e[512], e[511:0]);
                        end
                    end
                    accepted++;
                    last_acc_cyc = cyc;
                end
                if (s_en) begin
                    issued++;
                    addr_log.push_back(s_addr);
                end
                if (issued - accepted > max_out) max_out = issued - accepted;
                stall = m_tvalid && !m_tready;
                hold_d = m_tdata;
                hold_l = m_tlast;
            end
        end
    end

    // One launch: queue expectations, pulse start, wait (bounded) for done.
    task automatic run(input logic [10:0] rs, input logic [11:0] cnt, input logic [4:0] lc,
                       input int rdy_pct, input int restart_at,
                       output int start_c, output int done_c);
        logic [10:0] r;
        r = rs;
        for (int k = 0; k < int'(cnt); k++) begin
            exp_q.push_back({(k == int'(cnt) - 1), exp_row(r, lc)});
            r = r + 11'd1;
        end
        addr_log.delete();
        seen_vld = 1'b0;
        row_start = rs;
        row_count = cnt;
        last_col = lc;
        start = 1'b1;
        m_tready = rdy(rdy_pct);
        start_c = cyc;
        tick();
        start = 1'b0;
        done_c = -1;
        for (int t = 0; t < 6000; t++) begin
            if (t == 0) chk("busy after start", 512'(busy), 512'(cnt != 12'd0));
            if (done) begin
                done_c = cyc;
                break;
            end
            start = (t == restart_at);
            if (t == restart_at) begin
                row_start = 11'd500;
                row_count = 12'd2;
            end
            m_tready = rdy(rdy_pct);
            tick();
        end
        start = 1'b0;
        if (done_c < 0) begin
            compared++;
            mismatched++;
            $display("FAIL timeout: done not seen within budget, required a done pulse");
        end else begin
            chk("busy low at done", 512'(busy), 512'(0));
        end
        m_tready = 1'b1;
        tick();
        chk("done one cycle", 512'(done), 512'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc, dc, iss0;
        bit bad;
        logic [16:0] w[$];

        repeat (3) tick();
        chk("reset s_en", 512'(s_en), 512'(0));
        chk("reset s_addr", 512'(s_addr), 512'(0));
        chk("reset m_tvalid", 512'(m_tvalid), 512'(0));
        chk("reset m_tlast", 512'(m_tlast), 512'(0));
        chk("reset m_tdata", m_tdata, 512'(0));
        chk("reset busy", 512'(busy), 512'(0));
        chk("reset done", 512'(done), 512'(0));
        resetn = 1'b1;
        m_tready = 1'b1;
        tick();

        // Rows 5..8 with ready held high.
        run(11'd5, 12'd4, 5'd31, 100, -1, sc, dc);
        chk("t1 first valid latency", 512'(first_vld_cyc - sc), 512'(LAT + 1));
        chk("t1 back-to-back beats", 512'(last_acc_cyc - first_vld_cyc), 512'(3));
        chk("t1 done after last accept", 512'(dc - last_acc_cyc), 512'(1));
        chk("t1 all delivered", 512'(exp_q.size()), 512'(0));
        w.delete();
        w.push_back(17'h00140); w.push_back(17'h00180);
        w.push_back(17'h001C0); w.push_back(17'h00200);
        chk_addrs("t1 s_addr", w);

        // Wrap from row 2047 to row 0, with lanes above 7 masked when enabled.
        run(11'd2046, 12'd3, 5'd7, 100, -1, sc, dc);
        chk("t2 all delivered", 512'(exp_q.size()), 512'(0));
        w.delete();
        w.push_back(17'h1FF80); w.push_back(17'h1FFC0); w.push_back(17'h00000);
        chk_addrs("t2 s_addr", w);

        // Random backpressure.
        max_out = 0;
        run(11'd100, 12'd16, 5'd31, 50, -1, sc, dc);
        chk("t3 all delivered", 512'(exp_q.size()), 512'(0));
        chk("t3 outstanding over depth", 512'(max_out > DEPTH), 512'(0));
        chk("t3 done after last accept", 512'(dc - last_acc_cyc), 512'(1));

        // Empty readback.
        iss0 = issued;
        run(11'd77, 12'd0, 5'd31, 100, -1, sc, dc);
        chk("t4 done after start", 512'(dc - sc), 512'(1));
        chk("t4 reads issued", 512'(issued - iss0), 512'(0));
        chk("t4 valid seen", 512'(seen_vld), 512'(0));

        // A second start mid-transfer must be ignored.
        run(11'd10, 12'd8, 5'd31, 100, 3, sc, dc);
        chk("t5 all delivered", 512'(exp_q.size()), 512'(0));
        w.delete();
        for (int i = 0; i < 8; i++) w.push_back({11'(10 + i), 6'b0});
        chk_addrs("t5 s_addr", w);

        // Reset in the middle of a stalled transfer.
        row_start = 11'd40;
        row_count = 12'd10;
        m_tready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("t6 valid before reset", 512'(m_tvalid), 512'(1));
        resetn = 1'b0;
        #1;
        chk("t6 reset s_en", 512'(s_en), 512'(0));
        chk("t6 reset m_tvalid", 512'(m_tvalid), 512'(0));
        chk("t6 reset m_tlast", 512'(m_tlast), 512'(0));
        chk("t6 reset m_tdata", m_tdata, 512'(0));
        chk("t6 reset busy", 512'(busy), 512'(0));
        chk("t6 reset done", 512'(done), 512'(0));
        tick();
        tick();
        resetn = 1'b1;
        m_tready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            tick();
            bad = bad | m_tvalid;
        end
        chk("t6 stale data after reset", 512'(bad), 512'(0));

        // Full bank after reset, wrapping back through row_start-1.
        run(11'd1000, 12'd2048, 5'd31, 100, -1, sc, dc);
        chk("t7 all delivered", 512'(exp_q.size()), 512'(0));
        chk("t7 reads issued", 512'(addr_log.size()), 512'(2048));
        if (addr_log.size() == 2048) begin
            chk("t7 wrap row 0", 512'(addr_log[1048]), 512'(17'h00000));
            chk("t7 final row", 512'(addr_log[2047]), 512'({11'd999, 6'b0}));
        end
        chk("t7 done after last accept", 512'(dc - last_acc_cyc), 512'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
